// File: rtl/SB_WARMBOOT.sv
// Behavioural stand-in for the iCE40 SB_WARMBOOT cell so warmboot_ctrl elaborates
// outside the vendor flow; leave this file out where the technology library supplies the cell.
module SB_WARMBOOT (
    input logic BOOT,
    input logic S1,
    input logic S0
);

    logic unused_pins;
    assign unused_pins = ^{BOOT, S1, S0};

endmodule

// File: rtl/warmboot_ctrl.sv
// iCE40 warm-boot sequencer: accepts a boot request (image + delay), counts the
// delay down and raises BOOT with S1/S0 held stable; optional self-arm after reset.
module warmboot_ctrl #(
    parameter int unsigned NUM_IMAGES    = 4,
    parameter int unsigned DELAY_W       = 30,
    parameter bit          AUTO_BOOT     = 1'b0,
    parameter int unsigned DEFAULT_IMAGE = 0,
    parameter int unsigned DEFAULT_DELAY = 239_999_999,
    parameter bit          USE_PRIMITIVE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_image,
    input  logic [DELAY_W-1:0] req_delay,
    input  logic               cancel,
    output logic               req_err,
    output logic               busy,
    output logic               fired,
    output logic [DELAY_W-1:0] remaining,
    output logic               boot,
    output logic               s1,
    output logic               s0
);

    localparam logic [1:0]         DEF_IMAGE = 2'(DEFAULT_IMAGE);
    localparam logic [DELAY_W-1:0] DEF_DELAY = DELAY_W'(DEFAULT_DELAY);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRED
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [DELAY_W-1:0] rem_q, rem_d;
    logic               boot_q, boot_d;
    logic               err_q, err_d;
    logic               auto_q, auto_d;
    logic               accept;
    logic               img_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rem_q   <= '0;
            boot_q  <= 1'b0;
            err_q   <= 1'b0;
            auto_q  <= AUTO_BOOT;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            boot_q  <= boot_d;
            err_q   <= err_d;
            auto_q  <= auto_d;
        end
    end

    always_comb begin
        req_ready = !rst && (state_q != FIRED) && !cancel;
        accept    = req_valid && req_ready;
        img_ok    = 32'(req_image) < NUM_IMAGES;

        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        err_d   = accept && !img_ok;
        auto_d  = auto_q && !accept && !cancel;

        case (state_q)
            IDLE: begin
                if (accept && img_ok) begin
                    state_d = ARMED;
                    sel_d   = req_image;
                    rem_d   = req_delay;
                end else if (AUTO_BOOT && auto_q && !accept && !cancel) begin
                    state_d = ARMED;
                    sel_d   = DEF_IMAGE;
                    rem_d   = DEF_DELAY;
                end
            end
            ARMED: begin
                // A rejected request leaves the running countdown untouched.
                if (accept && img_ok) begin
                    sel_d = req_image;
                    rem_d = req_delay;
                end else if (cancel) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    rem_d   = '0;
                end else if (rem_q != '0) begin
                    rem_d = rem_q - DELAY_W'(1);
                end else begin
                    state_d = FIRED;
                end
            end
            FIRED: begin
                state_d = FIRED;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                rem_d   = '0;
            end
        endcase

        // Registered so the primitive sees a glitch-free BOOT edge.
        boot_d = (state_d == FIRED);
    end

    assign req_err   = err_q;
    assign busy      = (state_q == ARMED);
    assign fired     = (state_q == FIRED);
    assign remaining = rem_q;
    assign boot      = boot_q;
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];

    generate
        if (USE_PRIMITIVE) begin : g_prim
            SB_WARMBOOT u_warmboot (
                .BOOT (boot_q),
                .S1   (sel_q[1]),
                .S0   (sel_q[0])
            );
        end
    endgenerate

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Bench for warmboot_ctrl: constant vector table, a long max-delay countdown,
// randomized traffic against a deadline-based model, and auto-arm sequences.
module tb_warmboot_ctrl;

    localparam int DW       = 8;
    localparam int NUM_MAIN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req_valid, cancel;
    logic [1:0]    req_image;
    logic [DW-1:0] req_delay;
    logic          req_ready, req_err, busy, fired, boot, s1, s0;
    logic [DW-1:0] remaining;

    logic          a_rst, a_valid, a_cancel;
    logic [1:0]    a_image;
    logic [DW-1:0] a_delay;
    logic          a_ready, a_err, a_busy, a_fired, a_boot, a_s1, a_s0;
    logic [DW-1:0] a_remaining;

    int n_chk  = 0;
    int n_fail = 0;

    warmboot_ctrl #(
        .NUM_IMAGES    (NUM_MAIN),
        .DELAY_W       (DW),
        .AUTO_BOOT     (1'b0),
        .DEFAULT_IMAGE (0),
        .DEFAULT_DELAY (100),
        .USE_PRIMITIVE (1'b0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_image (req_image),
        .req_delay (req_delay),
        .cancel    (cancel),
        .req_err   (req_err),
        .busy      (busy),
        .fired     (fired),
        .remaining (remaining),
        .boot      (boot),
        .s1        (s1),
        .s0        (s0)
    );

    warmboot_ctrl #(
        .NUM_IMAGES    (2),
        .DELAY_W       (DW),
        .AUTO_BOOT     (1'b1),
        .DEFAULT_IMAGE (1),
        .DEFAULT_DELAY (7),
        .USE_PRIMITIVE (1'b0)
    ) u_auto (
        .clk       (clk),
        .rst       (a_rst),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_image (a_image),
        .req_delay (a_delay),
        .cancel    (a_cancel),
        .req_err   (a_err),
        .busy      (a_busy),
        .fired     (a_fired),
        .remaining (a_remaining),
        .boot      (a_boot),
        .s1        (a_s1),
        .s0        (a_s0)
    );

    typedef struct {
        logic       r, v;
        logic [1:0] img;
        logic [7:0] dly;
        logic       c;
        logic       rdy, bsy, fir, bt;
        logic [1:0] sel;
        logic [7:0] rem;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [1:0] img, logic [7:0] dly, logic c,
                                logic rdy, logic bsy, logic fir, logic bt, logic [1:0] sel,
                                logic [7:0] rem, logic err);
        vec_t x;
        x.r = r; x.v = v; x.img = img; x.dly = dly; x.c = c;
        x.rdy = rdy; x.bsy = bsy; x.fir = fir; x.bt = bt; x.sel = sel; x.rem = rem; x.err = err;
        return x;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [1:0] i,
                         input logic [7:0] d, input logic c);
        rst = r; req_valid = v; req_image = i; req_delay = d; cancel = c;
        @(negedge clk);
    endtask

    task automatic a_apply(input logic r, input logic v, input logic [1:0] i,
                           input logic [7:0] d, input logic c);
        a_rst = r; a_valid = v; a_image = i; a_delay = d; a_cancel = c;
        @(negedge clk);
    endtask

    task automatic a_step(input string tag, input logic bsy, input logic bt,
                          input logic [1:0] sel, input logic [7:0] rem, input logic err);
        @(posedge clk); #1;
        chk({tag, " busy"}, a_busy, bsy);
        chk({tag, " boot"}, a_boot, bt);
        chk({tag, " fired"}, a_fired, bt);
        chk({tag, " sel"}, {a_s1, a_s0}, sel);
        chk({tag, " remaining"}, a_remaining, rem);
        chk({tag, " req_err"}, a_err, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         m_armed, m_fired, e_rdy, e_err;
        logic [1:0] m_img;
        longint     cyc, fire_at;
        logic       r, v, c;
        logic [1:0] im;
        logic [7:0] d;

        rst = 1'b1; req_valid = 1'b0; req_image = '0; req_delay = '0; cancel = 1'b0;
        a_rst = 1'b1; a_valid = 1'b0; a_image = '0; a_delay = '0; a_cancel = 1'b0;

        // ---------------- table-driven vectors ----------------
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,2,5,0, 1,1,0,0,2,5,0));
        for (int k = 4; k >= 0; k--) tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,2,8'(k),0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,2,0,0));
        tbl.push_back(mk(0,1,1,3,0, 0,0,1,1,2,0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,1,1,2,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,10,0, 1,1,0,0,1,10,0));
        for (int k = 9; k >= 6; k--) tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,1,8'(k),0));
        tbl.push_back(mk(0,1,3,2,0, 1,1,0,0,3,2,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,3,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,3,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,3,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,2,20,0, 1,1,0,0,2,20,0));
        for (int k = 19; k >= 16; k--) tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,2,8'(k),0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0, 1,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0, 1,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,2,4,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,3,255,0, 1,1,0,0,3,255,0));

        foreach (tbl[n]) begin
            apply(tbl[n].r, tbl[n].v, tbl[n].img, tbl[n].dly, tbl[n].c);
            chk($sformatf("vec%0d req_ready", n), req_ready, tbl[n].rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d busy", n), busy, tbl[n].bsy);
            chk($sformatf("vec%0d fired", n), fired, tbl[n].fir);
            chk($sformatf("vec%0d boot", n), boot, tbl[n].bt);
            chk($sformatf("vec%0d sel", n), {s1, s0}, tbl[n].sel);
            chk($sformatf("vec%0d remaining", n), remaining, tbl[n].rem);
            chk($sformatf("vec%0d req_err", n), req_err, tbl[n].err);
        end

        // ---------------- maximum delay runs to completion ----------------
        for (int t = 1; t <= 255; t++) begin
            apply(0, 0, 0, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("maxdly t%0d remaining", t), remaining, 255 - t);
            chk($sformatf("maxdly t%0d boot", t), boot, 0);
        end
        apply(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("maxdly boot", boot, 1);
        chk("maxdly sel", {s1, s0}, 3);

        // ---------------- randomized traffic vs deadline model ----------------
        m_armed = 0; m_fired = 0; m_img = 0; cyc = 0; fire_at = 0;
        for (int n = 0; n < 1500; n++) begin
            r  = (n < 2) || ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 3) == 0);
            im = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
            c  = ($urandom_range(0, 15) == 0);
            apply(r, v, im, d, c);
            e_rdy = !r && !m_fired && !c;
            chk("rnd req_ready", req_ready, e_rdy);
            @(posedge clk); #1;
            cyc++;
            e_err = 0;
            if (r) begin
                m_armed = 0; m_fired = 0; m_img = 0;
            end else if (v && e_rdy && int'(im) < NUM_MAIN) begin
                m_armed = 1; m_img = im; fire_at = cyc + longint'(d) + 1;
            end else begin
                if (v && e_rdy) e_err = 1;
                if (c && m_armed) begin
                    m_armed = 0; m_img = 0;
                end else if (m_armed && cyc == fire_at) begin
                    m_armed = 0; m_fired = 1;
                end
            end
            chk("rnd busy", busy, m_armed);
            chk("rnd fired", fired, m_fired);
            chk("rnd boot", boot, m_fired);
            chk("rnd sel", {s1, s0}, m_img);
            chk("rnd remaining", remaining, m_armed ? fire_at - cyc - 1 : 0);
            chk("rnd req_err", req_err, e_err);
        end

        // ---------------- auto-arm instance ----------------
        a_apply(1, 0, 0, 0, 0);
        chk("auto rst ready", a_ready, 0);
        a_step("auto rst", 0, 0, 0, 0, 0);
        a_apply(0, 0, 0, 0, 0);
        a_step("auto arm", 1, 0, 1, 7, 0);
        for (int k = 6; k >= 0; k--) begin
            a_apply(0, 0, 0, 0, 0);
            a_step($sformatf("auto cnt%0d", k), 1, 0, 1, 8'(k), 0);
        end
        a_apply(0, 0, 0, 0, 0);
        a_step("auto fire", 0, 1, 1, 0, 0);
        a_apply(0, 1, 0, 0, 0);
        chk("auto fired ready", a_ready, 0);
        a_step("auto fired hold", 0, 1, 1, 0, 0);

        a_apply(1, 0, 0, 0, 0);
        a_step("auto rst2", 0, 0, 0, 0, 0);
        a_apply(0, 0, 0, 0, 0);
        a_step("auto rearm", 1, 0, 1, 7, 0);
        for (int k = 6; k >= 3; k--) begin
            a_apply(0, 0, 0, 0, 0);
            a_step($sformatf("auto cnt2_%0d", k), 1, 0, 1, 8'(k), 0);
        end
        a_apply(1, 0, 0, 0, 0);
        a_step("auto midrst", 0, 0, 0, 0, 0);
        a_apply(0, 0, 0, 0, 0);
        a_step("auto rearm2", 1, 0, 1, 7, 0);

        a_apply(0, 0, 0, 0, 1);
        a_step("auto cancel", 0, 0, 0, 0, 0);
        a_apply(0, 0, 0, 0, 0);
        a_step("auto stays idle", 0, 0, 0, 0, 0);
        a_apply(0, 1, 3, 5, 0);
        chk("auto badimg ready", a_ready, 1);
        a_step("auto badimg", 0, 0, 0, 0, 1);
        a_apply(0, 0, 0, 0, 0);
        a_step("auto err clear", 0, 0, 0, 0, 0);
        a_apply(0, 1, 1, 2, 0);
        a_step("auto goodimg", 1, 0, 1, 2, 0);

        a_apply(1, 0, 0, 0, 0);
        a_step("auto rst3", 0, 0, 0, 0, 0);
        a_apply(0, 1, 0, 3, 0);
        a_step("auto req wins", 1, 0, 0, 3, 0);
        for (int k = 2; k >= 0; k--) begin
            a_apply(0, 0, 0, 0, 0);
            a_step($sformatf("auto cnt3_%0d", k), 1, 0, 0, 8'(k), 0);
        end
        a_apply(0, 0, 0, 0, 0);
        a_step("auto fire3", 0, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/warmboot_ctrl.md
# warmboot_ctrl

Parametrised iCE40 warm-boot sequencer. It arms a programmable countdown, latches the target image select (S1/S0), and raises BOOT when the countdown expires. Requests come over a valid/ready handshake and may be cancelled or retargeted before firing. An optional auto-arm mode reproduces a fixed "boot image N after T cycles" behaviour with no external logic. It sits at the top level beside the user logic and drives the `SB_WARMBOOT` primitive directly.

## Interface
- `NUM_IMAGES`, 4: number of valid images, 1..4; `req_image >= NUM_IMAGES` is rejected.
- `DELAY_W`, 30: width of the delay counter and `req_delay`.
- `AUTO_BOOT`, 0: 1 = self-arm after reset with the default image and delay.
- `DEFAULT_IMAGE`, 0: image used by auto-arm; must be < `NUM_IMAGES`.
- `DEFAULT_DELAY`, 239_999_999: delay used by auto-arm (5 s at 48 MHz).
- `USE_PRIMITIVE`, 1: 1 = instantiate `SB_WARMBOOT` driven by `boot`/`s1`/`s0`; 0 = ports only (simulation).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: boot request strobe.
- `req_ready` out 1: request can be accepted this cycle.
- `req_image` in 2: target image index.
- `req_delay` in DELAY_W: countdown length in cycles.
- `cancel` in 1: abort an armed countdown.
- `req_err` out 1: one-cycle pulse when an out-of-range image is requested.
- `busy` out 1: high in ARMED.
- `fired` out 1: high in FIRED (sticky).
- `remaining` out DELAY_W: current countdown value; 0 outside ARMED.
- `boot`, `s1`, `s0` out 1 each: warm-boot primitive controls.

## Operation
- States: IDLE, ARMED, FIRED.
- Reset values: state IDLE; `boot`, `s1`, `s0`, `busy`, `fired`, `req_err` = 0; `remaining` = 0. `req_ready` = 0 while `rst` is high.
- Combinational ready: `req_ready = !rst && state != FIRED && !cancel`.
- Accept: a request is accepted when `req_valid && req_ready`.
  - Valid image: `{s1,s0} <= req_image`, `remaining <= req_delay`, state → ARMED.
  - Out-of-range image: `req_err` pulses for 1 cycle; state, `s1/s0` and `remaining` are unchanged.
- Retarget: an accepted request in ARMED reloads the image and delay and restarts the countdown.
- ARMED:
  - If `remaining != 0`: `remaining` decrements by 1 per cycle.
  - If `remaining == 0`: state → FIRED, and `boot` goes to 1 on that edge.
- `cancel` in ARMED: state → IDLE; `s1`, `s0`, `remaining` → 0; `boot` is never raised. `cancel` in IDLE or FIRED has no effect.
- FIRED: `boot`, `s1/s0` and `fired` are held until `rst`. All requests are ignored (`req_ready` = 0).
- Auto-arm (`AUTO_BOOT` = 1): on the first edge in IDLE with `rst` low, an internal `auto_pending` flag loads `DEFAULT_IMAGE`/`DEFAULT_DELAY` and moves to ARMED.
  - `auto_pending` is set by reset and cleared on arming, on any accepted request, or on `cancel`.
  - An external request in the same cycle wins over auto-arm.
- Arithmetic: `remaining` is an unsigned DELAY_W counter. It never wraps; decrement is suppressed at 0.

## Timing
- Request accepted at edge k with delay D: `busy` = 1 after edge k; `boot` rises at edge k+D+1.
  - D = 0 → `boot` rises 1 cycle after accept.
  - Maximum D = 2^DELAY_W − 1.
- `s1/s0` are stable at least 1 cycle before `boot` rises and are never changed while `boot` is high, as `SB_WARMBOOT` requires.
- Retarget at edge j with delay D2: `boot` rises at edge j+D2+1.
- `cancel` and `req_valid` in the same cycle: `cancel` wins and the request is not accepted.
- `cancel` in the same cycle that `remaining == 0` in ARMED: `cancel` wins and the block returns to IDLE.
- `rst` mid-countdown: on the next edge every output takes its reset value. With `AUTO_BOOT` = 1 the block re-arms the cycle after `rst` falls.
- `req_err` is registered and asserted for exactly 1 cycle per rejected request.

## Test plan
- Basic fire: request image 2, delay 5 at edge 10 → `busy` from edge 10; `remaining` 5,4,…,0; `boot` = 1 at edge 16 with `{s1,s0}` = 2, held until `rst`.
- Cancel: request delay 20, assert `cancel` 4 cycles later → IDLE next edge; `boot`, `s1`, `s0`, `remaining` = 0; a new request is accepted on the following cycle.
- Retarget: request image 1 / delay 10, then image 3 / delay 2 at `remaining` = 6 → `boot` rises 3 cycles after the retarget with `{s1,s0}` = 3.
- Errors and ignored requests:
  - With `NUM_IMAGES` = 2, request image 3 → one `req_err` pulse; state stays IDLE.
  - A request while FIRED → `req_ready` = 0; no change.
- Auto-arm: `AUTO_BOOT` = 1, `DEFAULT_IMAGE` = 1, `DEFAULT_DELAY` = 7; release `rst` at edge 0 → ARMED at edge 1, `boot` at edge 9 with `{s1,s0}` = 1. Asserting `rst` at `remaining` = 3 clears all outputs and re-arms after release.
- Boundaries:
  - Delay 0 → `boot` 1 cycle after accept.
  - `cancel` coincident with `remaining` = 0 → no boot.
  - `cancel` coincident with `req_valid` in IDLE → request not accepted.
